// File: rtl/sig_mon_pkg.sv
// sig_mon_pkg: shared state encoding and sizing helper for sig_stability_monitor
package sig_mon_pkg;
   typedef enum logic [1:0] {IDLE, ARM, SETTLE, STABLE} mon_state_e;
   function automatic int stab_w(input int min_stable);
      return $clog2(min_stable + 1);
   endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter, clr wins over inc
// ports: clk, rst (async active-low), clr (sync clear), inc (count enable), cnt (value)
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/sig_stability_monitor.sv
// sig_stability_monitor: samples sig, emits edge pulses, enforces a minimum stable window
// ports: clk, rst (async active-low), sig, en, clr (sync counter/sticky clear),
//   rise_o/fall_o/chg_o/viol_o (one-cycle pulses), stable_o, viol_sticky_o, chg_cnt_o, viol_cnt_o
module sig_stability_monitor
   import sig_mon_pkg::*;
#(
   parameter int MIN_STABLE = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig,
   input  logic             en,
   input  logic             clr,
   output logic             rise_o,
   output logic             fall_o,
   output logic             chg_o,
   output logic             stable_o,
   output logic             viol_o,
   output logic             viol_sticky_o,
   output logic [CNT_W-1:0] chg_cnt_o,
   output logic [CNT_W-1:0] viol_cnt_o
);
   localparam int SW = stab_w(MIN_STABLE);

   if (MIN_STABLE < 1) begin : g_bad_min_stable
      $error("MIN_STABLE must be >= 1");
   end

   mon_state_e    state;
   logic          sig_q;
   logic [SW-1:0] stab_cnt;
   logic [SW-1:0] stab_nxt;
   logic          chg;
   logic          rep;
   logic          vio;

   assign chg      = sig != sig_q;
   assign stab_nxt = stab_cnt + 1'b1;
   // edges are only reported once armed; ARM just captures the baseline sample
   assign rep      = en && (state == SETTLE || state == STABLE) && chg;
   assign vio      = en && state == SETTLE && chg;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state         <= IDLE;
         sig_q         <= 1'b0;
         stab_cnt      <= '0;
         rise_o        <= 1'b0;
         fall_o        <= 1'b0;
         chg_o         <= 1'b0;
         viol_o        <= 1'b0;
         stable_o      <= 1'b0;
         viol_sticky_o <= 1'b0;
      end else begin
         sig_q         <= sig;
         rise_o        <= rep && sig;
         fall_o        <= rep && !sig;
         chg_o         <= rep;
         viol_o        <= vio;
         viol_sticky_o <= clr ? 1'b0 : (viol_sticky_o || vio);
         if (!en) begin
            state    <= IDLE;
            stable_o <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= ARM;
               ARM: begin
                  state    <= SETTLE;
                  stab_cnt <= '0;
               end
               SETTLE:
                  if (chg) stab_cnt <= '0;
                  else begin
                     stab_cnt <= stab_nxt;
                     if (stab_nxt == SW'(MIN_STABLE)) begin
                        state    <= STABLE;
                        stable_o <= 1'b1;
                     end
                  end
               STABLE:
                  if (chg) begin
                     state    <= SETTLE;
                     stable_o <= 1'b0;
                     stab_cnt <= '0;
                  end
               default: state <= IDLE;
            endcase
         end
      end

   sat_counter #(.W(CNT_W)) u_chg_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .inc(rep),
      .cnt(chg_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_viol_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .inc(vio),
      .cnt(viol_cnt_o)
   );
endmodule

// File: tb/tb_sig_stability_monitor.sv
// tb_sig_stability_monitor: directed + random stimulus checked against a time-based reference model
module tb_sig_stability_monitor;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sig = 1'b0;
   logic en  = 1'b0;
   logic clr = 1'b0;
   logic rise0, fall0, chg0, stab0, viol0, stk0;
   logic [15:0] cc0, vc0;
   logic rise1, fall1, chg1, stab1, viol1, stk1;
   logic [1:0] cc1, vc1;
   int tests = 0;
   int fails = 0;
   logic cur = 1'b0;

   always #5 clk = ~clk;

   sig_stability_monitor #(.MIN_STABLE(4), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .sig(sig), .en(en), .clr(clr),
      .rise_o(rise0), .fall_o(fall0), .chg_o(chg0), .stable_o(stab0),
      .viol_o(viol0), .viol_sticky_o(stk0), .chg_cnt_o(cc0), .viol_cnt_o(vc0)
   );

   sig_stability_monitor #(.MIN_STABLE(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .sig(sig), .en(en), .clr(clr),
      .rise_o(rise1), .fall_o(fall1), .chg_o(chg1), .stable_o(stab1),
      .viol_o(viol1), .viol_sticky_o(stk1), .chg_cnt_o(cc1), .viol_cnt_o(vc1)
   );

   // model: r is the edge of the last reported change (or of arming);
   // sig counts as stable once MIN_STABLE edges have passed since r
   int ms[2] = '{4, 1};
   int mx[2] = '{65535, 3};
   int n = 0;
   int k[2], r[2];
   logic prv[2];
   int e_r[2], e_f[2], e_c[2], e_s[2], e_v[2], e_k[2], e_cc[2], e_vc[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         k[i] = 0; r[i] = 0; prv[i] = 1'b0;
         e_r[i] = 0; e_f[i] = 0; e_c[i] = 0; e_s[i] = 0;
         e_v[i] = 0; e_k[i] = 0; e_cc[i] = 0; e_vc[i] = 0;
      end
   endtask

   task automatic model_edge();
      int rep, v;
      n++;
      if (!rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         rep = 0; v = 0;
         if (!en) begin
            k[i] = 0; e_s[i] = 0;
         end else begin
            k[i]++;
            if (k[i] == 2) r[i] = n;
            rep = (k[i] >= 3 && sig != prv[i]) ? 1 : 0;
            v = (rep == 1 && (n - 1 - r[i]) < ms[i]) ? 1 : 0;
            if (rep == 1) r[i] = n;
            e_s[i] = (k[i] >= 2 && (n - r[i]) >= ms[i]) ? 1 : 0;
         end
         e_c[i] = rep;
         e_r[i] = (rep == 1 && sig) ? 1 : 0;
         e_f[i] = (rep == 1 && !sig) ? 1 : 0;
         e_v[i] = v;
         if (clr) begin
            e_cc[i] = 0; e_vc[i] = 0; e_k[i] = 0;
         end else begin
            e_cc[i] = (e_cc[i] + rep > mx[i]) ? mx[i] : e_cc[i] + rep;
            e_vc[i] = (e_vc[i] + v > mx[i]) ? mx[i] : e_vc[i] + v;
            e_k[i] = (e_k[i] == 1 || v == 1) ? 1 : 0;
         end
         prv[i] = sig;
      end
   endtask

   task automatic chk_dut(input int i, input logic ri, fa, ch, st, vi, sk,
                          input logic [31:0] cc, vc);
      chk($sformatf("d%0d rise", i), 32'(ri), e_r[i]);
      chk($sformatf("d%0d fall", i), 32'(fa), e_f[i]);
      chk($sformatf("d%0d chg", i), 32'(ch), e_c[i]);
      chk($sformatf("d%0d stable", i), 32'(st), e_s[i]);
      chk($sformatf("d%0d viol", i), 32'(vi), e_v[i]);
      chk($sformatf("d%0d sticky", i), 32'(sk), e_k[i]);
      chk($sformatf("d%0d chg_cnt", i), cc, e_cc[i]);
      chk($sformatf("d%0d viol_cnt", i), vc, e_vc[i]);
   endtask

   task automatic check_all();
      chk_dut(0, rise0, fall0, chg0, stab0, viol0, stk0, 32'(cc0), 32'(vc0));
      chk_dut(1, rise1, fall1, chg1, stab1, viol1, stk1, 32'(cc1), 32'(vc1));
   endtask

   task automatic step(input logic s, input logic e, input logic c);
      sig = s; en = e; clr = c;
      @(posedge clk);
      model_edge();
      #1 check_all();
   endtask

   task automatic hold(input int cnt);
      for (int j = 0; j < cnt; j++) step(cur, 1'b1, 1'b0);
   endtask

   task automatic toggle(input logic c);
      cur = ~cur;
      step(cur, 1'b1, c);
   endtask

   initial begin
      int p;
      logic e, c;
      model_reset();
      // reset held with sig=1, en=1, then arm on a quiet signal
      cur = 1'b1;
      for (int j = 0; j < 5; j++) step(cur, 1'b1, 1'b0);
      rst = 1'b1;
      hold(8);
      chk("arm stable", 32'(stab0), 1);
      // clean falling edge, then recovery
      toggle(1'b0);
      chk("clean fall", 32'(fall0), 1);
      hold(6);
      // glitch: two changes two edges apart
      toggle(1'b0);
      hold(1);
      toggle(1'b0);
      chk("glitch viol", 32'(viol0), 1);
      hold(6);
      // saturation on the narrow-counter instance
      step(cur, 1'b1, 1'b1);
      for (int j = 0; j < 5; j++) begin
         toggle(1'b0);
         if (j == 1) chk("sat cnt2", 32'(cc1), 2);
         hold(5);
      end
      chk("sat hold", 32'(cc1), 3);
      // build viol_cnt to 2, then collide clr with a violating change
      step(cur, 1'b1, 1'b1);
      for (int j = 0; j < 2; j++) begin
         toggle(1'b0);
         hold(1);
         toggle(1'b0);
         hold(6);
      end
      chk("pre clr viol_cnt", 32'(vc0), 2);
      toggle(1'b0);
      hold(1);
      toggle(1'b1);
      chk("clr viol pulse", 32'(viol0), 1);
      chk("clr viol_cnt", 32'(vc0), 0);
      hold(6);
      // disable mid-settle, re-enable
      toggle(1'b0);
      step(cur, 1'b0, 1'b0);
      step(cur, 1'b0, 1'b0);
      hold(7);
      // async reset between edges during settle
      toggle(1'b0);
      hold(1);
      #2 rst = 1'b0;
      model_reset();
      #1 check_all();
      step(cur, 1'b1, 1'b0);
      rst = 1'b1;
      hold(6);
      // randomized phases with varying change density
      for (int b = 0; b < 25; b++) begin
         case ($urandom_range(2))
            0: p = 2;
            1: p = 8;
            default: p = 20;
         endcase
         for (int j = 0; j < 15; j++) begin
            if ($urandom_range(p - 1) == 0) cur = ~cur;
            e = $urandom_range(29) != 0;
            c = $urandom_range(39) == 0;
            step(cur, e, c);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sig_stability_monitor.md
Name: sig_stability_monitor

Overview:
- Synthesizable consumer of the single-bit `sig` that the global-clock assertion checks watch.
- Samples `sig` on the global clock (posedge `clk`) and emits registered rise, fall and change pulses.
- Enforces a minimum stable window after every change and counts changes and stability violations.
- Feeds status and counters to the debug/CSR layer, so failures remain visible in silicon where assertions are compiled out.

Parameters:
- MIN_STABLE, 4, consecutive unchanged samples required after a change before `sig` counts as stable; legal range ≥1, elaboration error otherwise.
- CNT_W, 16, width of the change and violation counters.

Ports:
- clk  input  1  global clock; all sampling on posedge.
- rst  input  1  asynchronous, active-low reset.
- sig  input  1  monitored signal, assumed already synchronous to clk.
- en  input  1  monitor enable.
- clr  input  1  synchronous clear of counters and sticky flag.
- rise_o  output  1  one-cycle pulse: 0→1 sampled.
- fall_o  output  1  one-cycle pulse: 1→0 sampled.
- chg_o  output  1  one-cycle pulse: any change sampled.
- stable_o  output  1  sig has held for ≥MIN_STABLE samples.
- viol_o  output  1  one-cycle pulse: change sampled while settling.
- viol_sticky_o  output  1  set by any violation, cleared by clr or reset.
- chg_cnt_o  output  CNT_W  saturating count of reported changes.
- viol_cnt_o  output  CNT_W  saturating count of violations.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - sig_q, all outputs, both counters and stab_cnt go to 0.
  - Takes effect immediately, including mid-settle.
- sig_q holds the previous sample. A change at edge N means sig(N) ≠ sig_q.
- Pulses are registered at edge N and high for exactly the cycle after N (one-cycle latency).
- FSM states: IDLE, ARM, SETTLE, STABLE.
- IDLE:
  - sig_q tracks sig; no pulses; stable_o=0; counters hold.
  - en=1 → ARM.
- ARM (one cycle):
  - Captures sig into sig_q; no edge is reported.
  - Sets stab_cnt=0 and goes to SETTLE.
- SETTLE:
  - A sampled change fires viol_o, sets viol_sticky, increments viol_cnt, and also fires rise/fall/chg and increments chg_cnt.
  - On a change, stab_cnt is set to 0 and the state stays SETTLE.
  - With no change, stab_cnt increments. When stab_cnt+1 == MIN_STABLE, go to STABLE and set stable_o=1 at that edge.
- STABLE:
  - A change fires rise/fall/chg, increments chg_cnt, clears stable_o at the same edge, sets stab_cnt=0 and goes to SETTLE.
- Timing example: a change sampled at edge N followed by quiet gives stable_o=1 from edge N+MIN_STABLE.
- en=0 in any state:
  - Go to IDLE at the next edge.
  - stable_o goes to 0 and no pulses fire at that edge.
  - Counters and sticky flag hold.
- Counters saturate at 2^CNT_W−1 and never wrap.
- clr has priority over a same-cycle increment: the counter becomes 0 and the sticky flag becomes 0. clr does not alter state, stab_cnt or pulses.
- stab_cnt width is $clog2(MIN_STABLE+1).
- With MIN_STABLE=1, any two changes on consecutive edges give one violation.

Decomposition:
- Package sig_mon_pkg:
  - State enum mon_state_e: IDLE, ARM, SETTLE, STABLE.
  - Localparam function computing the stab_cnt width.
- One sub-module sat_counter (param W; ports clk, rst, clr, inc, cnt):
  - Saturating counter with clr priority.
  - Instantiated twice, for changes and violations.
- FSM, sampling and pulse registers live in the top module.

Test Plan (MIN_STABLE=4, CNT_W=16 unless noted):
- Reset and arm:
  - Stimulus: hold rst=0 with sig=1 and en=1 for 5 cycles, then release; enable with sig=1 and no change.
  - While in reset: all outputs 0.
  - After release: no pulses during ARM; stable_o=1 exactly 4 edges after ARM; chg_cnt=0.
- Clean edges:
  - Stimulus: from STABLE, drive sig 1→0 sampled at edge 10.
  - fall_o=1 and chg_o=1 for one cycle after edge 10; rise_o=0.
  - stable_o falls at edge 10 and rises at edge 14; chg_cnt=1; viol_cnt=0.
- Glitch:
  - Stimulus: changes sampled at edges 10 and 12.
  - viol_o pulses once after edge 12; viol_cnt=1; viol_sticky=1; chg_cnt=2.
  - stable_o rises at edge 16.
- Saturation (CNT_W=2):
  - Stimulus: 5 changes spaced 6 cycles apart.
  - chg_cnt=3 after the 3rd change and holds at 3; no violations.
- clr collision:
  - Stimulus: clr=1 on the same edge as a violating change, with viol_cnt previously 2.
  - viol_cnt=0, chg_cnt=0, viol_sticky=0; viol_o still pulses for that edge.
- Mid-operation disable and reset:
  - en=0 during SETTLE: IDLE next edge, stable_o=0, counters hold.
  - Re-enable, then assert rst asynchronously between edges during SETTLE: outputs go to 0 immediately, without waiting for clk.
